// File: rtl/permute_sched.sv
// Frame scheduler for an external lane-permute network: generates per-lane destinations
// and registers the network result. Optional table check: PERMUTE_SCHED_CONFLICT_CHECK_EN.
`ifndef P
`define P 4
`endif
`ifndef MAP
`define MAP 3
`endif

module permute_sched #(
    parameter int N    = 2*`P,
    parameter int W    = 1,
    parameter int SELW = `MAP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [$clog2(N)-1:0] cfg_idx,
    input  logic [SELW-1:0]      cfg_dest,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [$clog2(N)-1:0] k,
    input  logic [15:0]          beats,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*W-1:0]       in_data,
    output logic [N*W-1:0]       pn_in_bus,
    output logic [N*SELW-1:0]    pn_dest_bus,
    input  logic [N*W-1:0]       pn_out_bus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*W-1:0]       out_data
`ifdef PERMUTE_SCHED_CONFLICT_CHECK_EN
    ,
    output logic                 err
`endif
);
    localparam int LOGN = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_d;
    logic [1:0]      mode_q;
    logic [LOGN-1:0] k_q;
    logic [15:0]     cnt;
    logic [SELW-1:0] tbl [N];
    logic            accept, out_fire, start_go, done_d;

    function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        r = '0;
        for (int b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
        return r;
    endfunction

    assign busy      = (state != IDLE);
    assign pn_in_bus = in_data;
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

`ifdef PERMUTE_SCHED_CONFLICT_CHECK_EN
    logic         table_ok, err_set;
    logic [N-1:0] seen;

    // A usable table maps every lane to a distinct in-range destination.
    always_comb begin
        seen     = '0;
        table_ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (32'(tbl[i]) >= N)
                table_ok = 1'b0;
            else if (seen[tbl[i][LOGN-1:0]])
                table_ok = 1'b0;
            else
                seen[tbl[i][LOGN-1:0]] = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        start_go = 1'b0;
        done_d   = 1'b0;
`ifdef PERMUTE_SCHED_CONFLICT_CHECK_EN
        err_set  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (beats == 16'd0)
                        done_d = 1'b1;
`ifdef PERMUTE_SCHED_CONFLICT_CHECK_EN
                    else if (mode == 2'd3 && !table_ok)
                        err_set = 1'b1;
`endif
                    else begin
                        start_go = 1'b1;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (accept && cnt == 16'd1) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_fire) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Destinations come only from latched mode/k and the table, never from live inputs.
    always_comb begin
        pn_dest_bus = '0;
        for (int i = 0; i < N; i++) begin
            case (mode_q)
                2'd0:    pn_dest_bus[i*SELW +: SELW] = SELW'(LOGN'(i));
                2'd1:    pn_dest_bus[i*SELW +: SELW] = SELW'(LOGN'(i) ^ (LOGN'(1) << k_q));
                2'd2:    pn_dest_bus[i*SELW +: SELW] = SELW'(bit_rev(LOGN'(i)));
                default: pn_dest_bus[i*SELW +: SELW] = tbl[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            mode_q    <= 2'd0;
            k_q       <= '0;
            cnt       <= 16'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < N; i++) tbl[i] <= SELW'(i);
        end else begin
            done <= done_d;
            if (start_go) begin
                mode_q <= mode;
                k_q    <= k;
                cnt    <= beats;
            end else if (accept) begin
                cnt <= cnt - 16'd1;
            end
            if (cfg_we && state == IDLE) tbl[cfg_idx] <= cfg_dest;
            // Capturing a new beat takes priority; it also covers a same-cycle drain.
            if (accept) begin
                out_data  <= pn_out_bus;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PERMUTE_SCHED_CONFLICT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        err <= 1'b0;
        else if (err_set)  err <= 1'b1;
        else if (start_go) err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_permute_sched.sv
// Self-checking bench for permute_sched with a scatter-network stub and a lane-level reference model.
`timescale 1ns/1ps
module tb_permute_sched;
    localparam int N = 8, W = 8, SELW = 3, LOGN = 3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0, cfg_dest = '0;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic [2:0]  k = '0;
    logic [15:0] beats = '0;
    logic        busy, done, in_ready, out_valid;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0, pn_in_bus, pn_out_bus, out_data;
    logic [23:0] pn_dest_bus;
`ifdef PERMUTE_SCHED_CONFLICT_CHECK_EN
    logic        err;
`endif

    int n_cmp = 0, n_bad = 0;
    logic [2:0] tb_tbl [8];

    permute_sched #(.N(N), .W(W), .SELW(SELW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_dest(cfg_dest),
        .start(start), .mode(mode), .k(k), .beats(beats), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pn_in_bus(pn_in_bus), .pn_dest_bus(pn_dest_bus), .pn_out_bus(pn_out_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PERMUTE_SCHED_CONFLICT_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Permute network stub: input lane i lands on output lane dest[i].
    always_comb begin
        pn_out_bus = '0;
        for (int i = 0; i < N; i++)
            pn_out_bus[int'(pn_dest_bus[i*SELW +: SELW])*W +: W] = pn_in_bus[i*W +: W];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_dest(input int m, input int kk, input int i);
        int r;
        r = 0;
        case (m)
            0: r = i;
            1: r = i ^ (1 << kk);
            2: for (int b = 0; b < LOGN; b++) r = r * 2 + ((i >> b) & 1);
            default: r = int'(tb_tbl[i]);
        endcase
        return r;
    endfunction

    function automatic logic [23:0] ref_dest_bus(input int m, input int kk);
        logic [23:0] o;
        o = '0;
        for (int i = 0; i < N; i++) o[i*SELW +: SELW] = 3'(ref_dest(m, kk, i));
        return o;
    endfunction

    function automatic logic [63:0] ref_perm(input logic [63:0] d, input int m, input int kk);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < N; i++) o[ref_dest(m, kk, i)*W +: W] = d[i*W +: W];
        return o;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input int val);
        cfg_we = 1'b1;
        cfg_idx = 3'(idx);
        cfg_dest = 3'(val);
        step;
        cfg_we = 1'b0;
        tb_tbl[idx] = 3'(val);
    endtask

    task automatic load_random_perm;
        int p[8];
        int j, t;
        for (int i = 0; i < N; i++) p[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        for (int i = 0; i < N; i++) cfg_write(i, p[i]);
    endtask

    // flow: 0 = full rate, 1 = random valid/ready, 2 = 5-cycle output stall
    task automatic run_frame(input int m, input int kk, input int nb, input int flow);
        int acc, rcv, cyc;
        bit mv, exp_rdy, fin;
        logic [63:0] md;
        acc = 0; rcv = 0; cyc = 0; mv = 0; fin = 0; md = '0;
        mode = 2'(m); k = 3'(kk); beats = 16'(nb); start = 1'b1;
        step;
        start = 1'b0;
        check("busy_run", busy, 1);
        while (!fin && cyc < 300) begin
            in_valid  = (flow == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = {$urandom, $urandom};
            out_ready = (flow == 1) ? ($urandom_range(0, 3) != 0) :
                        (flow == 2 && cyc >= 2 && cyc < 7) ? 1'b0 : 1'b1;
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_idx   = 3'($urandom);
            cfg_dest  = 3'($urandom);
            start     = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            exp_rdy = (acc < nb) && (!mv || out_ready);
            check("dest_bus", pn_dest_bus, ref_dest_bus(m, kk));
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, mv);
            if (mv) check("out_data", out_data, md);
            check("done_low", done, 0);
            if (mv && out_ready) begin rcv++; mv = 0; end
            if (in_valid && exp_rdy) begin md = ref_perm(in_data, m, kk); mv = 1; acc++; end
            if (rcv == nb) fin = 1;
            step;
            cyc++;
        end
        cfg_we = 1'b0; in_valid = 1'b0; start = 1'b0;
        if (!fin) check("frame_timeout", 0, 1);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        check("out_valid_end", out_valid, 0);
        step;
        check("done_once", done, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) tb_tbl[i] = 3'(i);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_dest", pn_dest_bus, ref_dest_bus(0, 0));
`ifdef PERMUTE_SCHED_CONFLICT_CHECK_EN
        check("rst_err", err, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step;

        run_frame(1, 0, 3, 0);
        check("xor_k0_dest", pn_dest_bus, 24'hDE54C1);
        run_frame(2, 0, 4, 1);
        check("rev_lane1", pn_dest_bus[3 +: 3], 4);
        check("rev_lane3", pn_dest_bus[9 +: 3], 6);
        check("rev_lane6", pn_dest_bus[18 +: 3], 3);
        run_frame(0, 0, 6, 2);

        beats = 16'd0; start = 1'b1;
        step;
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        step;
        check("zero_done_once", done, 0);
        check("zero_busy2", busy, 0);

        load_random_perm;
        run_frame(3, 0, 5, 1);
        for (int f = 0; f < 6; f++)
            run_frame($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(1, 8),
                      $urandom_range(0, 2));

        cfg_write(2, 1);
        cfg_write(5, 1);
`ifdef PERMUTE_SCHED_CONFLICT_CHECK_EN
        mode = 2'd3; beats = 16'd4; start = 1'b1;
        step;
        start = 1'b0;
        check("dup_err", err, 1);
        check("dup_busy", busy, 0);
        step;
        check("dup_err_sticky", err, 1);
        check("dup_busy2", busy, 0);
        check("dup_no_done", done, 0);
        cfg_write(2, 2);
        cfg_write(5, 5);
        run_frame(3, 0, 2, 0);
        check("err_cleared", err, 0);
`else
        run_frame(3, 0, 4, 1);
`endif

        load_random_perm;
        mode = 2'd3; beats = 16'd4; start = 1'b1;
        step;
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = {$urandom, $urandom};
        step;
        step;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) tb_tbl[i] = 3'(i);
        step;
        check("midrst_no_done", done, 0);
        check("midrst_idle", busy, 0);
        run_frame(3, 0, 5, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
